// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and transmitter.
//   uart_state_e         : receive FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   ClocksPerBaudDefault : default clock cycles per bit period
//   DataBits / StopBits  : 8N1 frame shape
//   BitCntW              : width of a counter indexing the data bits
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam int unsigned ClocksPerBaudDefault = 16;
  localparam int unsigned DataBits             = 8;
  localparam int unsigned StopBits             = 1;
  localparam int unsigned BitCntW              = $clog2(DataBits);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk_i    : destination clock
//   rst_ni   : asynchronous active-low reset; both flops load ResetVal
//   async_i  : asynchronous input
//   sync_o   : input synchronised to clk_i (two cycles of latency)
module uart_rx_sync #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], async_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: recovers 8N1 frames from i_RX, sampling each bit at mid-period, and
// presents each good byte on a one-entry valid/ready holding register.
//   p_CLOCKS_PER_BAUD : clock cycles per bit period (must be >= 4)
//   i_CLK             : clock, rising edge
//   i_RESET_N         : asynchronous active-low reset
//   i_RX              : asynchronous serial line, idles high
//   i_RX_READY        : consumer accepts o_RX_DATA while o_RX_VALID is high
//   o_RX_DATA         : last received byte, stable while o_RX_VALID
//   o_RX_VALID        : byte available, held until accepted
//   o_RX_BUSY         : receiver is not idle
//   o_FRAME_ERR       : one-cycle pulse, stop bit sampled low
//   o_OVERRUN         : one-cycle pulse, good byte dropped because the holding register was full
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned p_CLOCKS_PER_BAUD = ClocksPerBaudDefault
) (
  input  logic                i_CLK,
  input  logic                i_RESET_N,
  input  logic                i_RX,
  input  logic                i_RX_READY,
  output logic [DataBits-1:0] o_RX_DATA,
  output logic                o_RX_VALID,
  output logic                o_RX_BUSY,
  output logic                o_FRAME_ERR,
  output logic                o_OVERRUN
);

  localparam int unsigned     CntW      = $clog2(p_CLOCKS_PER_BAUD);
  localparam int unsigned     Half      = p_CLOCKS_PER_BAUD / 2;
  localparam logic [CntW-1:0] CntHalfM1 = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntLast   = CntW'(p_CLOCKS_PER_BAUD - 1);
  localparam logic [BitCntW-1:0] BitLast = BitCntW'(DataBits - 1);

  logic rx_s;
  logic rx_s_dly_q, rx_s_dly_d;

  uart_state_e         state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic [DataBits-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  uart_rx_sync #(
    .ResetVal (1'b1)
  ) u_rx_sync (
    .clk_i   (i_CLK),
    .rst_ni  (i_RESET_N),
    .async_i (i_RX),
    .sync_o  (rx_s)
  );

  always_comb begin
    rx_s_dly_d  = rx_s;
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (valid_q && i_RX_READY) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // Edge-triggered start: a held-low line (break) cannot retrigger.
        if (rx_s_dly_q && !rx_s) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalfM1) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end else begin
            state_d = StIdle;  // glitch, drop silently
          end
        end
      end
      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[DataBits-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        // Leave mid-stop-bit so a start edge right after the stop bit is caught.
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s) begin
            if (!valid_q || i_RX_READY) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      rx_s_dly_q  <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_s_dly_q  <= rx_s_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_RX_DATA   = data_q;
  assign o_RX_VALID  = valid_q;
  assign o_RX_BUSY   = (state_q != StIdle);
  assign o_FRAME_ERR = frame_err_q;
  assign o_OVERRUN   = overrun_q;

endmodule
